crtc_dma_arbiter: RTL and testbench
===================================

Name: crtc_dma_arbiter

Overview:
- CPU-side responder for the CRTC row-fetch DMA handshake (busreq/busack).
- On a CRTC busreq it asks the Z80 for the bus, waits for the CPU bus acknowledge and a settle interval, then grants the bus to the CRTC.
- While granted, it steers the CRTC DMA address onto the shared video RAM port and returns read data.
- Sits between the CPU core, the main RAM port and the crtc block.

Parameters:
ADR_W, 17, RAM address width (matches CRTC ram_adr).
SETTLE, 2, clk cycles between CPU bus acknowledge and CRTC grant (bus turnaround); range 0..15.
HOLDOFF, 4, minimum clk cycles the CPU owns the bus after a release before a new request is forwarded; range 0..15.
ACK_TIMEOUT, 1023, clk cycles of waiting for CPU acknowledge before ack_timeout is flagged.

Ports:
clk  in  1  system clock (same domain as crtc clk)
rst_n  in  1  asynchronous active-low reset
crtc_busreq  in  1  DMA request from CRTC, level, synchronous to clk
crtc_busack  out  1  DMA grant to CRTC, level
crtc_adr  in  ADR_W  CRTC DMA read address
crtc_data  out  8  RAM read data to CRTC (pass-through of ram_dout)
cpu_busrq_n  out  1  Z80 BUSRQ, active low
cpu_busak_n  in  1  Z80 BUSAK, active low, synchronous to clk
cpu_adr  in  ADR_W  CPU memory address (bank-extended)
cpu_dout  in  8  CPU write data
cpu_mem_we  in  1  CPU memory write strobe, one clk
ram_adr  out  ADR_W  shared RAM address
ram_din  out  8  shared RAM write data
ram_we  out  1  shared RAM write enable
ram_dout  in  8  shared RAM read data, synchronous 1-cycle latency
dma_active  out  1  high while the CRTC owns RAM (for wait/debug)
ack_timeout  out  1  sticky flag: CPU acknowledge exceeded ACK_TIMEOUT

Behaviour:
- Reset values:
  - crtc_busack=0, cpu_busrq_n=1, ram_we=0, dma_active=0, ack_timeout=0.
  - ram_adr follows cpu_adr.
  - State IDLE; all counters 0.
- States: IDLE, REQ, SETTLE, GRANT, HOLD.
- IDLE:
  - ram_adr=cpu_adr, ram_din=cpu_dout, ram_we=cpu_mem_we.
  - crtc_busreq=1 → REQ; cpu_busrq_n goes 0 on the same edge.
- REQ:
  - cpu_busrq_n=0. The 10-bit wait counter increments each cycle.
  - When the counter reaches ACK_TIMEOUT, set ack_timeout (sticky until reset) and keep waiting.
  - cpu_busak_n=0 → SETTLE with the settle counter cleared. If SETTLE=0, go directly to GRANT.
  - crtc_busreq drops while in REQ and cpu_busak_n=1 → IDLE, cpu_busrq_n=1. This is a withdrawn request; no grant is issued.
- SETTLE:
  - ram_we forced 0; ram_adr=crtc_adr.
  - After SETTLE cycles → GRANT.
  - crtc_busreq drops → HOLD.
- GRANT:
  - crtc_busack=1, dma_active=1.
  - ram_adr=crtc_adr (combinational), ram_we=0, crtc_data=ram_dout. RAM data is valid one cycle after the address.
  - crtc_busreq=0 → HOLD: crtc_busack=0 and cpu_busrq_n=1 on the same edge. The address mux returns to the CPU side.
- HOLD:
  - CPU owns RAM (IDLE muxing).
  - After HOLDOFF cycles → IDLE. A pending crtc_busreq is then honoured immediately.
  - HOLDOFF=0 → HOLD lasts one cycle.
- CPU writes:
  - cpu_mem_we asserted outside IDLE/HOLD is ignored; ram_we stays 0.
  - A correct Z80 cannot write while BUSAK is low.
- Simultaneous events:
  - crtc_busreq rising in the same cycle HOLD expires → enters REQ next cycle.
  - cpu_busak_n rising during GRANT (protocol error): the grant is held until crtc_busreq drops.
- Counters saturate; none wrap.
- Reset mid-GRANT: busack and busrq_n release asynchronously. The CRTC sees busack=0 and stalls in its wait state until re-granted.

Decomposition:
- Shared package holds:
  - the state encoding (3-bit enum: IDLE=0, REQ=1, SETTLE=2, GRANT=3, HOLD=4);
  - the counter widths (4-bit settle/holdoff, 10-bit timeout).
- One sub-module is natural: crtc_dma_addr_mux. It is the combinational RAM address/data/we steering, selected by the granted bit.

Test Plan:
- Reset → cpu_busrq_n=1, crtc_busack=0, ram_adr equals cpu_adr=0x1234.
- Basic fetch: crtc_busreq=1 → cpu_busrq_n=0 next cycle; BUSAK low 5 cycles later → crtc_busack=1 exactly SETTLE(2) cycles after. Then:
  - drive crtc_adr=0x1F300;
  - the next-cycle crtc_data equals RAM contents there;
  - 120 sequential reads match a preloaded pattern.
- Release: crtc_busreq=0 → busack=0 and cpu_busrq_n=1 same edge. A re-request within HOLDOFF(4) cycles does not drive cpu_busrq_n low until cycle 5.
- Withdrawn request: busreq pulse of 3 cycles with BUSAK held high → cpu_busrq_n returns to 1, busack never asserts.
- Timeout: BUSAK held high 1023 cycles → ack_timeout=1. It stays 1 after the later grant until rst_n pulse.
- Write blocking + async reset: cpu_mem_we during GRANT → ram_we=0. rst_n low mid-GRANT → busack=0, busrq_n=1 without a clock edge.

Source files
------------

// File: rtl/crtc_dma_arbiter_pkg.sv
// Shared types and counter widths for the CRTC row-fetch DMA arbiter.
// The state encoding is fixed so debug taps read the same on every build.
package crtc_dma_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GRANT  = 3'd3,
    ST_HOLD   = 3'd4
  } arb_state_t;

  localparam int SETTLE_CNT_W = 4;
  localparam int HOLD_CNT_W   = 4;
  localparam int WAIT_CNT_W   = 10;

  // Saturating increment: the acknowledge wait counter never wraps.
  function automatic logic [WAIT_CNT_W-1:0] wait_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/crtc_dma_addr_mux.sv
// Shared RAM port steering: CPU side by default, CRTC DMA address once the
// bus has been handed over. CPU writes only pass while the CPU truly owns RAM.
module crtc_dma_addr_mux #(
  parameter int ADR_W = 17
) (
  input  logic             dma_sel,
  input  logic             cpu_we_en,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [ADR_W-1:0] crtc_adr,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_mem_we,
  output logic [ADR_W-1:0] ram_adr,
  output logic [7:0]       ram_din,
  output logic             ram_we
);

  genvar gi;
  generate
    for (gi = 0; gi < ADR_W; gi++) begin : g_adr
      assign ram_adr[gi] = dma_sel ? crtc_adr[gi] : cpu_adr[gi];
    end
  endgenerate

  assign ram_din = cpu_dout;
  assign ram_we  = cpu_mem_we & cpu_we_en & ~dma_sel;

endmodule

// File: rtl/crtc_dma_arbiter.sv
// CPU-side responder for the CRTC busreq/busack DMA handshake: requests the
// Z80 bus, waits for BUSAK plus a turnaround interval, then grants the CRTC.
module crtc_dma_arbiter
  import crtc_dma_arbiter_pkg::*;
#(
  parameter int ADR_W       = 17,
  parameter int SETTLE      = 2,
  parameter int HOLDOFF     = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             crtc_busreq,
  output logic             crtc_busack,
  input  logic [ADR_W-1:0] crtc_adr,
  output logic [7:0]       crtc_data,
  output logic             cpu_busrq_n,
  input  logic             cpu_busak_n,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_mem_we,
  output logic [ADR_W-1:0] ram_adr,
  output logic [7:0]       ram_din,
  output logic             ram_we,
  input  logic [7:0]       ram_dout,
  output logic             dma_active,
  output logic             ack_timeout
);

  // Terminal counts; a zero HOLDOFF still costs one HOLD cycle.
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [HOLD_CNT_W-1:0]   HOLD_LAST   = HOLD_CNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
  localparam logic [WAIT_CNT_W-1:0]   ACK_LIMIT   = WAIT_CNT_W'(ACK_TIMEOUT);

  arb_state_t              state_reg;
  logic [SETTLE_CNT_W-1:0] settle_cnt_reg;
  logic [HOLD_CNT_W-1:0]   hold_cnt_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_next;
  logic                    busack_reg;
  logic                    busrq_n_reg;
  logic                    dma_active_reg;
  logic                    ack_timeout_reg;
  logic                    dma_sel;
  logic                    cpu_we_en;

  assign wait_cnt_next = wait_inc(wait_cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      settle_cnt_reg  <= '0;
      hold_cnt_reg    <= '0;
      wait_cnt_reg    <= '0;
      busack_reg      <= 1'b0;
      busrq_n_reg     <= 1'b1;
      dma_active_reg  <= 1'b0;
      ack_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (crtc_busreq) begin
            state_reg    <= ST_REQ;
            busrq_n_reg  <= 1'b0;
            wait_cnt_reg <= '0;
          end
        end
        ST_REQ: begin
          wait_cnt_reg <= wait_cnt_next;
          if (wait_cnt_next >= ACK_LIMIT) ack_timeout_reg <= 1'b1;
          // BUSAK wins over a withdrawal: the CPU has already let go of the bus.
          if (!cpu_busak_n) begin
            if (SETTLE == 0) begin
              state_reg      <= ST_GRANT;
              busack_reg     <= 1'b1;
              dma_active_reg <= 1'b1;
            end else begin
              state_reg      <= ST_SETTLE;
              settle_cnt_reg <= '0;
            end
          end else if (!crtc_busreq) begin
            state_reg   <= ST_IDLE;
            busrq_n_reg <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!crtc_busreq) begin
            state_reg    <= ST_HOLD;
            busrq_n_reg  <= 1'b1;
            hold_cnt_reg <= '0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg      <= ST_GRANT;
            busack_reg     <= 1'b1;
            dma_active_reg <= 1'b1;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        ST_GRANT: begin
          // A BUSAK glitch here is ignored; only the CRTC ends the grant.
          if (!crtc_busreq) begin
            state_reg      <= ST_HOLD;
            busack_reg     <= 1'b0;
            dma_active_reg <= 1'b0;
            busrq_n_reg    <= 1'b1;
            hold_cnt_reg   <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_reg >= HOLD_LAST) state_reg <= ST_IDLE;
          else hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dma_sel   = (state_reg == ST_SETTLE) || (state_reg == ST_GRANT);
  assign cpu_we_en = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);

  crtc_dma_addr_mux #(.ADR_W(ADR_W)) u_addr_mux (
    .dma_sel    (dma_sel),
    .cpu_we_en  (cpu_we_en),
    .cpu_adr    (cpu_adr),
    .crtc_adr   (crtc_adr),
    .cpu_dout   (cpu_dout),
    .cpu_mem_we (cpu_mem_we),
    .ram_adr    (ram_adr),
    .ram_din    (ram_din),
    .ram_we     (ram_we)
  );

  assign crtc_data   = ram_dout;
  assign crtc_busack = busack_reg;
  assign cpu_busrq_n = busrq_n_reg;
  assign dma_active  = dma_active_reg;
  assign ack_timeout = ack_timeout_reg;

endmodule

// File: tb/tb_crtc_dma_arbiter.sv
// Bench for crtc_dma_arbiter: directed handshake scenarios plus random traffic,
// all checked every cycle against an edge-count based model of the handshake.
module tb_crtc_dma_arbiter;

  localparam int ADR_W       = 17;
  localparam int SETTLE      = 2;
  localparam int HOLDOFF     = 4;
  localparam int ACK_TIMEOUT = 1023;

  logic             clk;
  logic             rst_n;
  logic             crtc_busreq;
  logic             crtc_busack;
  logic [ADR_W-1:0] crtc_adr;
  logic [7:0]       crtc_data;
  logic             cpu_busrq_n;
  logic             cpu_busak_n;
  logic [ADR_W-1:0] cpu_adr;
  logic [7:0]       cpu_dout;
  logic             cpu_mem_we;
  logic [ADR_W-1:0] ram_adr;
  logic [7:0]       ram_din;
  logic             ram_we;
  logic [7:0]       ram_dout;
  logic             dma_active;
  logic             ack_timeout;

  int total = 0;
  int bad   = 0;

  crtc_dma_arbiter #(
    .ADR_W(ADR_W), .SETTLE(SETTLE), .HOLDOFF(HOLDOFF), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .crtc_busreq(crtc_busreq), .crtc_busack(crtc_busack),
    .crtc_adr(crtc_adr), .crtc_data(crtc_data),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_mem_we(cpu_mem_we),
    .ram_adr(ram_adr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dma_active(dma_active), .ack_timeout(ack_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preloaded RAM contents: a fixed function of the address.
  function automatic logic [7:0] pat(input logic [ADR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'b0};
  endfunction

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) ram_dout <= pat(ram_adr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: tracks edge numbers of the request, acknowledge and release, and
  // derives every output from distances between them.
  int n = 0;
  int req_edge = 0;
  int ack_edge = 0;
  int hold_until = 0;
  bit m_active = 0;
  bit m_acked = 0;
  bit m_busack = 0;
  bit m_timeout = 0;
  bit rd_valid = 0;
  logic [ADR_W-1:0] rd_adr = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0; hold_until = 0;
      m_active = 0; m_acked = 0; m_busack = 0; m_timeout = 0; rd_valid = 0;
    end else begin
      n++;
      rd_valid = m_busack;
      rd_adr   = crtc_adr;
      if (!m_active) begin
        if (crtc_busreq && n >= hold_until) begin
          m_active = 1; m_acked = 0; req_edge = n;
        end
      end else if (!m_acked) begin
        if (n - req_edge >= ACK_TIMEOUT) m_timeout = 1;
        if (!cpu_busak_n) begin
          m_acked = 1; ack_edge = n;
        end else if (!crtc_busreq) begin
          m_active = 0;
        end
      end else if (!crtc_busreq) begin
        m_active = 0; m_acked = 0;
        hold_until = n + ((HOLDOFF == 0) ? 1 : HOLDOFF) + 1;
      end
      m_busack = m_active && m_acked && (n >= ack_edge + SETTLE);
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("busrq_n", 32'(cpu_busrq_n), 32'(!m_active));
    chk("busack", 32'(crtc_busack), 32'(m_busack));
    chk("dma_active", 32'(dma_active), 32'(m_busack));
    chk("ack_timeout", 32'(ack_timeout), 32'(m_timeout));
    chk("ram_adr", 32'(ram_adr), 32'((m_active && m_acked) ? crtc_adr : cpu_adr));
    chk("ram_we", 32'(ram_we), 32'(cpu_mem_we && !m_active));
    if (!(m_active && m_acked)) chk("ram_din", 32'(ram_din), 32'(cpu_dout));
    if (rd_valid) chk("crtc_data", 32'(crtc_data), 32'(pat(rd_adr)));
  end

  int k;
  bit seen;
  logic [ADR_W-1:0] a;

  initial begin
    crtc_busreq = 0; crtc_adr = '0; cpu_busak_n = 1; cpu_adr = 17'h01234;
    cpu_dout = 8'h5A; cpu_mem_we = 0; rst_n = 1;
    #1 rst_n = 0;
    repeat (3) step();
    chk("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk("rst_busack", 32'(crtc_busack), 32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'h01234);
    chk("rst_timeout", 32'(ack_timeout), 32'd0);
    rst_n = 1;
    step();

    // Basic fetch
    crtc_busreq = 1;
    step();
    chk("req_busrq_n", 32'(cpu_busrq_n), 32'd0);
    repeat (4) step();
    cpu_busak_n = 0;
    k = 0;
    while (!crtc_busack && k < 20) begin step(); k++; end
    chk("grant_latency", 32'(k), 32'd3);
    crtc_adr = 17'h1F300;
    step();
    chk("first_read", 32'(crtc_data), 32'h73);
    for (int i = 1; i <= 120; i++) begin
      a = 17'h1F300 + 17'(i);
      crtc_adr = a;
      step();
      chk("seq_read", 32'(crtc_data), 32'(pat(a)));
    end

    // Release then early re-request
    crtc_busreq = 0; cpu_busak_n = 1;
    step();
    chk("rel_busack", 32'(crtc_busack), 32'd0);
    chk("rel_busrq_n", 32'(cpu_busrq_n), 32'd1);
    crtc_busreq = 1;
    k = 0;
    while (cpu_busrq_n && k < 20) begin step(); k++; end
    chk("rereq_delay", 32'(k), 32'd5);
    crtc_busreq = 0;
    repeat (2) step();

    // Withdrawn request
    seen = 0;
    crtc_busreq = 1;
    repeat (3) begin step(); seen |= crtc_busack; end
    chk("wd_busrq_low", 32'(cpu_busrq_n), 32'd0);
    crtc_busreq = 0;
    repeat (2) begin step(); seen |= crtc_busack; end
    chk("wd_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk("wd_no_ack", 32'(seen), 32'd0);

    // Acknowledge timeout, sticky through the later grant
    crtc_busreq = 1;
    repeat (1023) step();
    chk("to_early", 32'(ack_timeout), 32'd0);
    step();
    chk("to_set", 32'(ack_timeout), 32'd1);
    cpu_busak_n = 0;
    repeat (4) step();
    chk("to_grant", 32'(crtc_busack), 32'd1);
    chk("to_sticky", 32'(ack_timeout), 32'd1);

    // Write blocked during grant, then asynchronous reset mid-grant
    cpu_mem_we = 1;
    #1 chk("we_block", 32'(ram_we), 32'd0);
    rst_n = 0;
    #1;
    chk("arst_busack", 32'(crtc_busack), 32'd0);
    chk("arst_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk("arst_timeout", 32'(ack_timeout), 32'd0);
    cpu_mem_we = 0; crtc_busreq = 0; cpu_busak_n = 1;
    step();
    rst_n = 1;
    step();

    // Random traffic with a loosely behaved Z80
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) crtc_busreq = ~crtc_busreq;
      if (cpu_busrq_n) cpu_busak_n = 1;
      else if ($urandom_range(0, 3) == 0) cpu_busak_n = 0;
      if ($urandom_range(0, 49) == 0) cpu_busak_n = ~cpu_busak_n;
      cpu_adr    = 17'($urandom);
      crtc_adr   = 17'($urandom);
      cpu_dout   = 8'($urandom);
      cpu_mem_we = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
